reg_file_onehot: RTL and testbench
==================================

// Module: reg_file_onehot
// PURPOSE
//  16-entry general-purpose register file for the F7 datapath, directly downstream of the
//  4-to-16 destination decoder; the decoder's one-hot decOut drives the write-enables here.
//  Two synchronous read ports (rs/rt) with write-to-read bypass, R0 hardwired to zero, and a
//  sticky error flag for malformed (non-one-hot) write selects. Feeds the ALU operand stage.
// PARAMETERS
//  WIDTH      32          data width of each register
//  R0_ZERO    1           1: register 0 reads as 0 and ignores writes; 0: R0 is an ordinary reg
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-low reset (0 = reset asserted)
//  regWrite   in   1      write strobe; write occurs only when 1 at the clk edge
//  decOut     in   16     one-hot write select from the destination decoder (bit i -> Ri)
//  wrData     in   WIDTH  write data
//  rdAddr1    in   4      read port 1 address (rs)
//  rdAddr2    in   4      read port 2 address (rt)
//  rdData1    out  WIDTH  registered read data, port 1
//  rdData2    out  WIDTH  registered read data, port 2
//  selErr     out  1      sticky: a write was attempted with a non-one-hot decOut
//  wrCount    out  8      count of committed writes, wraps 255 -> 0
// BEHAVIOUR
//  Reset (reset=0, asynchronous, independent of clk): all 16 registers, rdData1, rdData2,
//   selErr and wrCount clear to 0. Reset asserted mid-write aborts the write: no register
//   keeps a partial value. Outputs stay 0 while reset=0.
//  Write: at posedge clk, if regWrite=1 and decOut has exactly one bit set (bit i),
//   Ri <= wrData and wrCount <= wrCount+1 (mod 256). If R0_ZERO=1 and i=0, the write is
//   discarded and wrCount does NOT increment (R0 stays 0).
//  Malformed select: regWrite=1 and decOut zero or with >=2 bits set -> no register written,
//   wrCount unchanged, selErr <= 1. selErr clears only on reset. regWrite=0 -> decOut ignored,
//   no error raised.
//  Read: 1-cycle latency. At posedge clk, rdDataN <= value of R[rdAddrN]; it is visible after
//   the edge and is held until the next edge.
//  Bypass: if the same edge commits a write to R[rdAddrN], rdDataN <= wrData (new value),
//   not the old contents. Applies to both ports independently; a discarded write (R0 with
//   R0_ZERO=1, or malformed select) never bypasses.
//  R0 read with R0_ZERO=1 always returns 0.
//  Both ports may address the same register in the same cycle; both return identical data.
//  No combinational path from any input to any output.
// TESTING
//  1 Reset: drive reset=0 after writing R5=0xDEADBEEF -> rdData1/2=0, selErr=0, wrCount=0
//    immediately, without a clk edge; after release, reading R5 returns 0.
//  2 Write/read all: write Ri=0x1000+i for i=1..15 (decOut=1<<i) -> each read returns
//    0x1000+i one cycle after rdAddr is presented; wrCount=15; R0 reads 0.
//  3 Bypass: same cycle regWrite=1, decOut=16'h0008, wrData=0xA5A5A5A5, rdAddr1=rdAddr2=3
//    -> after that edge rdData1=rdData2=0xA5A5A5A5.
//  4 Malformed select: regWrite=1, decOut=16'h0006, wrData=0xFFFFFFFF -> R1,R2 unchanged,
//    selErr=1, wrCount unchanged; then decOut=16'h0000 with regWrite=0 -> selErr stays 1.
//  5 R0 protection: regWrite=1, decOut=16'h0001, wrData=0x12345678, rdAddr1=0 -> rdData1=0,
//    wrCount unchanged, selErr=0.
//  6 Counter wrap: 256 valid writes to R7 -> wrCount returns to 0; reset asserted between
//    posedges during a write to R9 -> R9=0 after release.

Source files
------------

// File: rtl/reg_file_onehot.sv
// reg_file_onehot
// 16-entry register file for the F7 datapath. Writes are selected by the
// one-hot destination decoder output. There are two registered read ports
// (rs/rt), and each port sees a write made on the same edge. R0 can be
// hardwired to zero. A sticky flag records any write attempt whose select
// is not one-hot. An 8-bit counter tracks committed writes.
module reg_file_onehot #(
    parameter int WIDTH   = 32,
    parameter int R0_ZERO = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             regWrite,
    input  logic [15:0]      decOut,
    input  logic [WIDTH-1:0] wrData,
    input  logic [3:0]       rdAddr1,
    input  logic [3:0]       rdAddr2,
    output logic [WIDTH-1:0] rdData1,
    output logic [WIDTH-1:0] rdData2,
    output logic             selErr,
    output logic [7:0]       wrCount
);

    logic [WIDTH-1:0] r_regs [16];
    logic [WIDTH-1:0] r_rdData1;
    logic [WIDTH-1:0] r_rdData2;
    logic             r_selErr;
    logic [7:0]       r_wrCount;

    logic             w_oneHot;
    logic [3:0]       w_wrIdx;
    logic             w_r0Blocked;
    logic             w_commit;
    logic             w_selBad;
    logic [WIDTH-1:0] w_rd1Next;
    logic [WIDTH-1:0] w_rd2Next;

    // Decode the write select: confirm it is one-hot and recover the bit index.
    always_comb begin
        w_oneHot = (decOut != 16'h0000) && ((decOut & (decOut - 16'h0001)) == 16'h0000);
        w_wrIdx  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (decOut[i]) begin
                w_wrIdx = 4'(i);
            end
        end
    end

    // A write commits only for a well-formed select that is not aimed at a protected R0.
    always_comb begin
        w_r0Blocked = (R0_ZERO != 0) && (w_wrIdx == 4'd0);
        w_commit    = regWrite && w_oneHot && !w_r0Blocked;
        w_selBad    = regWrite && !w_oneHot;
    end

    // Choose the next read data per port: the committing write wins, then the protected R0, then storage.
    always_comb begin
        if (w_commit && (w_wrIdx == rdAddr1)) begin
            w_rd1Next = wrData;
        end else if ((R0_ZERO != 0) && (rdAddr1 == 4'd0)) begin
            w_rd1Next = '0;
        end else begin
            w_rd1Next = r_regs[rdAddr1];
        end

        if (w_commit && (w_wrIdx == rdAddr2)) begin
            w_rd2Next = wrData;
        end else if ((R0_ZERO != 0) && (rdAddr2 == 4'd0)) begin
            w_rd2Next = '0;
        end else begin
            w_rd2Next = r_regs[rdAddr2];
        end
    end

    // Register storage: only committed writes update an entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[w_wrIdx] <= wrData;
        end
    end

    // Registered read ports, the sticky select error and the write counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdData1 <= '0;
            r_rdData2 <= '0;
            r_selErr  <= 1'b0;
            r_wrCount <= 8'd0;
        end else begin
            r_rdData1 <= w_rd1Next;
            r_rdData2 <= w_rd2Next;
            if (w_selBad) begin
                r_selErr <= 1'b1;
            end
            if (w_commit) begin
                r_wrCount <= r_wrCount + 8'd1;
            end
        end
    end

    assign rdData1 = r_rdData1;
    assign rdData2 = r_rdData2;
    assign selErr  = r_selErr;
    assign wrCount = r_wrCount;

endmodule

// File: tb/tb_reg_file_onehot.sv
// tb_reg_file_onehot
// Scoreboarded bench for reg_file_onehot. Each driven cycle pushes the
// expected outputs from a reference model. The outputs are popped and
// compared 1 time unit after the following clock edge.
module tb_reg_file_onehot;

    logic        clk;
    logic        reset;
    logic        regWrite;
    logic [15:0] decOut;
    logic [31:0] wrData;
    logic [3:0]  rdAddr1;
    logic [3:0]  rdAddr2;
    logic [31:0] rdData1;
    logic [31:0] rdData2;
    logic        selErr;
    logic [7:0]  wrCount;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        err;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mRegs [16];
    logic        mErr;
    logic [7:0]  mCnt;
    int          checks   = 0;
    int          failures = 0;

    reg_file_onehot #(.WIDTH(32), .R0_ZERO(1)) dut (
        .clk(clk), .reset(reset), .regWrite(regWrite), .decOut(decOut),
        .wrData(wrData), .rdAddr1(rdAddr1), .rdAddr2(rdAddr2),
        .rdData1(rdData1), .rdData2(rdData2), .selErr(selErr), .wrCount(wrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clear the reference model to its reset state.
    task automatic modelReset();
        for (int i = 0; i < 16; i++) mRegs[i] = 32'h0;
        mErr = 1'b0;
        mCnt = 8'd0;
        q.delete();
    endtask

    // Drive one cycle, advance the model, push the expectation, then move to 1 unit past the edge.
    task automatic applyStimulus(input logic we, input logic [15:0] dec, input logic [31:0] data,
                                 input logic [3:0] a1, input logic [3:0] a2);
        exp_t e;
        int   idx;
        regWrite = we; decOut = dec; wrData = data; rdAddr1 = a1; rdAddr2 = a2;
        idx = -1;
        for (int i = 0; i < 16; i++) if (dec[i]) idx = i;
        if (we) begin
            if ($countones(dec) != 1) mErr = 1'b1;
            else if (idx != 0) begin
                mRegs[idx] = data;
                mCnt = mCnt + 8'd1;
            end
        end
        e.rd1 = mRegs[a1];
        e.rd2 = mRegs[a2];
        e.err = mErr;
        e.cnt = mCnt;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Reset the DUT and the model, and leave the bench 1 unit past a clock edge.
    task automatic doReset();
        regWrite = 1'b0; decOut = 16'h0; wrData = 32'h0; rdAddr1 = 4'd0; rdAddr2 = 4'd0;
        reset = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        checks += 4;
        if (rdData1 !== 32'h0) begin failures++; $display("[TB] FAIL reset_rd1 actual=%h expected=0", rdData1); end
        if (rdData2 !== 32'h0) begin failures++; $display("[TB] FAIL reset_rd2 actual=%h expected=0", rdData2); end
        if (selErr !== 1'b0) begin failures++; $display("[TB] FAIL reset_err actual=%b expected=0", selErr); end
        if (wrCount !== 8'h0) begin failures++; $display("[TB] FAIL reset_cnt actual=%0d expected=0", wrCount); end
        @(posedge clk); #1;
        reset = 1'b1;
        applyStimulus(1'b1, 16'h0020, 32'hDEADBEEF, 4'd5, 4'd5);
        applyStimulus(1'b0, 16'h0000, 32'h0, 4'd5, 4'd0);
        void'(q.pop_front());
        e = q.pop_front();
        checks++;
        if (rdData1 !== e.rd1) begin failures++; $display("[TB] FAIL r5_before_reset actual=%h expected=%h", rdData1, e.rd1); end
        #1 reset = 1'b0;
        #1;
        checks += 4;
        if (rdData1 !== 32'h0) begin failures++; $display("[TB] FAIL async_rd1 actual=%h expected=0", rdData1); end
        if (rdData2 !== 32'h0) begin failures++; $display("[TB] FAIL async_rd2 actual=%h expected=0", rdData2); end
        if (selErr !== 1'b0) begin failures++; $display("[TB] FAIL async_err actual=%b expected=0", selErr); end
        if (wrCount !== 8'h0) begin failures++; $display("[TB] FAIL async_cnt actual=%0d expected=0", wrCount); end
        modelReset();
        #1 reset = 1'b1;
        applyStimulus(1'b0, 16'h0000, 32'h0, 4'd5, 4'd5);
        e = q.pop_front();
        checks += 2;
        if (rdData1 !== e.rd1 || rdData1 !== 32'h0) begin failures++; $display("[TB] FAIL r5_after_reset actual=%h expected=%h", rdData1, e.rd1); end
        if (rdData2 !== e.rd2) begin failures++; $display("[TB] FAIL r5_after_reset_p2 actual=%h expected=%h", rdData2, e.rd2); end
    endtask

    task automatic test_write_read_all();
        exp_t e;
        applyStimulus(1'b0, 16'h0006, 32'hFFFFFFFF, 4'd0, 4'd0);
        e = q.pop_front();
        checks++;
        if (selErr !== e.err) begin failures++; $display("[TB] FAIL idle_no_err actual=%b expected=%b", selErr, e.err); end
        for (int i = 1; i < 16; i++) begin
            applyStimulus(1'b1, 16'h1 << i, 32'h1000 + i, 4'd0, 4'd0);
            e = q.pop_front();
        end
        checks++;
        if (wrCount !== e.cnt || wrCount !== 8'd15) begin failures++; $display("[TB] FAIL count15 actual=%0d expected=%0d", wrCount, e.cnt); end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 16'h0, 32'h0, 4'(i), 4'(15 - i));
            e = q.pop_front();
            checks += 2;
            if (rdData1 !== e.rd1) begin failures++; $display("[TB] FAIL read_p1 R%0d actual=%h expected=%h", i, rdData1, e.rd1); end
            if (rdData2 !== e.rd2) begin failures++; $display("[TB] FAIL read_p2 R%0d actual=%h expected=%h", 15 - i, rdData2, e.rd2); end
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        applyStimulus(1'b1, 16'h0008, 32'hA5A5A5A5, 4'd3, 4'd3);
        e = q.pop_front();
        checks += 2;
        if (rdData1 !== e.rd1) begin failures++; $display("[TB] FAIL bypass_p1 actual=%h expected=%h", rdData1, e.rd1); end
        if (rdData2 !== e.rd2) begin failures++; $display("[TB] FAIL bypass_p2 actual=%h expected=%h", rdData2, e.rd2); end
        applyStimulus(1'b1, 16'h0010, 32'h5A5A0004, 4'd4, 4'd3);
        e = q.pop_front();
        checks += 2;
        if (rdData1 !== e.rd1) begin failures++; $display("[TB] FAIL b2b_p1 actual=%h expected=%h", rdData1, e.rd1); end
        if (rdData2 !== e.rd2) begin failures++; $display("[TB] FAIL b2b_p2 actual=%h expected=%h", rdData2, e.rd2); end
    endtask

    task automatic test_r0();
        exp_t e;
        applyStimulus(1'b1, 16'h0001, 32'h12345678, 4'd0, 4'd0);
        e = q.pop_front();
        checks += 3;
        if (rdData1 !== e.rd1) begin failures++; $display("[TB] FAIL r0_bypass actual=%h expected=%h", rdData1, e.rd1); end
        if (wrCount !== e.cnt) begin failures++; $display("[TB] FAIL r0_cnt actual=%0d expected=%0d", wrCount, e.cnt); end
        if (selErr !== e.err) begin failures++; $display("[TB] FAIL r0_err actual=%b expected=%b", selErr, e.err); end
        applyStimulus(1'b0, 16'h0, 32'h0, 4'd0, 4'd0);
        e = q.pop_front();
        checks++;
        if (rdData2 !== e.rd2) begin failures++; $display("[TB] FAIL r0_read actual=%h expected=%h", rdData2, e.rd2); end
    endtask

    task automatic test_malformed();
        exp_t e;
        applyStimulus(1'b1, 16'h0006, 32'hFFFFFFFF, 4'd1, 4'd2);
        e = q.pop_front();
        checks += 4;
        if (rdData1 !== e.rd1) begin failures++; $display("[TB] FAIL bad_r1 actual=%h expected=%h", rdData1, e.rd1); end
        if (rdData2 !== e.rd2) begin failures++; $display("[TB] FAIL bad_r2 actual=%h expected=%h", rdData2, e.rd2); end
        if (selErr !== e.err) begin failures++; $display("[TB] FAIL bad_err actual=%b expected=%b", selErr, e.err); end
        if (wrCount !== e.cnt) begin failures++; $display("[TB] FAIL bad_cnt actual=%0d expected=%0d", wrCount, e.cnt); end
        applyStimulus(1'b0, 16'h0000, 32'h0, 4'd1, 4'd2);
        e = q.pop_front();
        checks += 2;
        if (selErr !== e.err) begin failures++; $display("[TB] FAIL err_sticky actual=%b expected=%b", selErr, e.err); end
        if (rdData1 !== e.rd1) begin failures++; $display("[TB] FAIL bad_r1_later actual=%h expected=%h", rdData1, e.rd1); end
        applyStimulus(1'b1, 16'h0000, 32'h77777777, 4'd1, 4'd2);
        e = q.pop_front();
        checks++;
        if (wrCount !== e.cnt) begin failures++; $display("[TB] FAIL zero_sel_cnt actual=%0d expected=%0d", wrCount, e.cnt); end
    endtask

    task automatic test_wrap();
        exp_t e;
        doReset();
        for (int k = 0; k < 256; k++) begin
            applyStimulus(1'b1, 16'h0080, 32'h7000 + k, 4'd7, 4'd0);
            e = q.pop_front();
            checks += 2;
            if (wrCount !== e.cnt) begin failures++; $display("[TB] FAIL wrap_cnt k=%0d actual=%0d expected=%0d", k, wrCount, e.cnt); end
            if (rdData1 !== e.rd1) begin failures++; $display("[TB] FAIL wrap_rd k=%0d actual=%h expected=%h", k, rdData1, e.rd1); end
        end
        checks++;
        if (wrCount !== 8'd0) begin failures++; $display("[TB] FAIL wrap_zero actual=%0d expected=0", wrCount); end
    endtask

    task automatic test_reset_mid_write();
        exp_t e;
        regWrite = 1'b1; decOut = 16'h0200; wrData = 32'hCAFEF00D; rdAddr1 = 4'd9; rdAddr2 = 4'd9;
        #2 reset = 1'b0;
        @(posedge clk); #1;
        regWrite = 1'b0; decOut = 16'h0;
        modelReset();
        reset = 1'b1;
        applyStimulus(1'b0, 16'h0, 32'h0, 4'd9, 4'd9);
        e = q.pop_front();
        checks += 3;
        if (rdData1 !== e.rd1 || rdData1 !== 32'h0) begin failures++; $display("[TB] FAIL r9_aborted actual=%h expected=%h", rdData1, e.rd1); end
        if (rdData2 !== e.rd2) begin failures++; $display("[TB] FAIL r9_aborted_p2 actual=%h expected=%h", rdData2, e.rd2); end
        if (wrCount !== e.cnt) begin failures++; $display("[TB] FAIL r9_cnt actual=%0d expected=%0d", wrCount, e.cnt); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        reset = 1'b0; regWrite = 1'b0; decOut = 16'h0; wrData = 32'h0; rdAddr1 = 4'd0; rdAddr2 = 4'd0;
        modelReset();
        #1;
        test_reset();
        test_write_read_all();
        test_bypass();
        test_r0();
        test_malformed();
        test_wrap();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
